// File: rtl/si_pkg.sv
// si_pkg
// Shared types and screen constants for the shooter game logic.
// Used by the player bullet, the enemy grid and the enemy-bullet logic.
//   bullet_state_t : player bullet FSM states (IDLE, FLIGHT, HOLD)
//   SCREEN_W/H     : visible playfield size in pixels
//   PARK_X/PARK_Y  : coordinates reported by a bullet that is not in flight
package si_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    HOLD   = 2'd2
  } bullet_state_t;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int PARK_X = 0;
  localparam int PARK_Y = 0;

endpackage

// File: rtl/player_bullet_rise_detect.sv
// rise_detect
// Rising-edge detector for an already-synchronised button level.
// One flop holds the previous level; the pulse is high for the single
// cycle in which the level is 1 and the previous level was 0.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-low reset (clears the history flop)
//   level  : button level input
//   rise   : one-cycle pulse on a 0->1 transition of level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/player_bullet.sv
// player_bullet
// Player shot controller. Launches a single bullet from the ship on a fire
// press, moves it up SPEED pixels per frame, parks it when the enemy grid
// reports a hit or when it leaves the top of the screen, then waits
// COOLDOWN frames before another launch is accepted. Also drives the
// bullet pixel for the colour mux and counts shots and misses.
//
// Build option: define AUTOFIRE_EN to let a held fire level relaunch as
// soon as the controller is back in IDLE (one shot per cooldown period).
// Without it, every launch needs a fresh rising edge of fire.
//
// Ports:
//   clk, reset       : system clock, synchronous active-low reset
//   fire             : fire button level (synchronised)
//   px               : ship centre x, captured at launch
//   frame_tick       : one-cycle pulse per video frame
//   b_hit            : collision flag from the enemy grid
//   vga_x, vga_y     : current scan position
//   bx, by           : bullet position, 0 while parked
//   active           : bullet in flight
//   pixel            : scan position lies on the bullet
//   shots, misses    : saturating launch / top-exit counters
module player_bullet
  import si_pkg::*;
#(
  parameter int SHIP_Y   = 220,
  parameter int SPEED    = 2,
  parameter int BW       = 1,
  parameter int BH       = 4,
  parameter int TOP_Y    = 0,
  parameter int COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [9:0] px,
  input  logic       frame_tick,
  input  logic       b_hit,
  input  logic [9:0] vga_x,
  input  logic [8:0] vga_y,
  output logic [9:0] bx,
  output logic [8:0] by,
  output logic       active,
  output logic       pixel,
  output logic [7:0] shots,
  output logic [7:0] misses
);

  localparam logic [8:0]  LAUNCH_Y   = 9'(SHIP_Y - BH);
  localparam logic [10:0] EXPIRE_LIM = 11'(TOP_Y + SPEED);

  bullet_state_t state, next_state;
  logic [7:0]    cd_cnt;
  logic          fire_rise;
  logic          launch_req;
  logic          at_top;

  rise_detect u_fire_rise (
    .clk   (clk),
    .reset (reset),
    .level (fire),
    .rise  (fire_rise)
  );

`ifdef AUTOFIRE_EN
  assign launch_req = fire | fire_rise;
`else
  assign launch_req = fire_rise;
`endif

  // Compare in 11 bits so TOP_Y + SPEED never wraps against the 9-bit row.
  assign at_top = ({2'b00, by} < EXPIRE_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A hit wins over the frame tick, so a bullet that collides in the same
  // cycle it would have moved is parked without moving or counting a miss.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (launch_req) next_state = FLIGHT;
      end
      FLIGHT: begin
        if (b_hit)                    next_state = HOLD;
        else if (frame_tick && at_top) next_state = HOLD;
      end
      HOLD: begin
        if (cd_cnt == 8'd0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Position, cooldown and counters follow the same state decisions as the
  // next-state logic; bx is only loaded at launch so later ship motion does
  // not drag the bullet sideways.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bx     <= 10'd0;
      by     <= 9'd0;
      cd_cnt <= 8'd0;
      shots  <= 8'd0;
      misses <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch_req) begin
            bx <= px;
            by <= LAUNCH_Y;
            if (shots != 8'hFF) shots <= shots + 8'd1;
          end
        end
        FLIGHT: begin
          if (b_hit) begin
            bx     <= 10'(PARK_X);
            by     <= 9'(PARK_Y);
            cd_cnt <= 8'(COOLDOWN);
          end else if (frame_tick) begin
            if (at_top) begin
              bx     <= 10'(PARK_X);
              by     <= 9'(PARK_Y);
              cd_cnt <= 8'(COOLDOWN);
              if (misses != 8'hFF) misses <= misses + 8'd1;
            end else begin
              by <= by - 9'(SPEED);
            end
          end
        end
        HOLD: begin
          if (frame_tick && (cd_cnt != 8'd0)) cd_cnt <= cd_cnt - 8'd1;
        end
        default: begin
          bx <= 10'(PARK_X);
          by <= 9'(PARK_Y);
        end
      endcase
    end
  end

  // Bounds use 11-bit sums so a bullet near the right or bottom edge cannot
  // wrap its far edge back to zero.
  always_comb begin
    active = (state == FLIGHT);
    pixel  = active
           && ({1'b0, vga_x} >= {1'b0, bx})
           && ({1'b0, vga_x} <  ({1'b0, bx} + 11'(BW)))
           && ({2'b00, vga_y} >= {2'b00, by})
           && ({2'b00, vga_y} <  ({2'b00, by} + 11'(BH)));
  end

endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet
// Directed bench for player_bullet. Stimulus pushes the hand-computed
// expected outputs into a scoreboard queue; a monitor on the falling clock
// edge pops each entry and compares it with what the DUT presents.
// Default parameters: launch row 216, 2 px per tick, 1x4 bullet, cooldown 8.
module tb_player_bullet;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] px = 10'd0;
  logic       frame_tick = 1'b0;
  logic       b_hit = 1'b0;
  logic [9:0] vga_x = 10'd0;
  logic [8:0] vga_y = 9'd0;
  logic [9:0] bx;
  logic [8:0] by;
  logic       active;
  logic       pixel;
  logic [7:0] shots;
  logic [7:0] misses;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    bit          is_pixel;
    logic [35:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [35:0] mon_act;

  player_bullet dut (
    .clk        (clk),
    .reset      (reset),
    .fire       (fire),
    .px         (px),
    .frame_tick (frame_tick),
    .b_hit      (b_hit),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .bx         (bx),
    .by         (by),
    .active     (active),
    .pixel      (pixel),
    .shots      (shots),
    .misses     (misses)
  );

  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the outputs held
  // mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.is_pixel) mon_act = {35'd0, pixel};
      else                mon_act = {active, bx, by, shots, misses};
      tests_run++;
      if (mon_act !== mon_e.exp) begin
        tests_failed++;
        if (mon_e.is_pixel)
          $display("[TB] FAIL %s: pixel got %0d, expected %0d", mon_e.name, mon_act[0], mon_e.exp[0]);
        else
          $display("[TB] FAIL %s: got active=%0d bx=%0d by=%0d shots=%0d misses=%0d, expected active=%0d bx=%0d by=%0d shots=%0d misses=%0d",
                   mon_e.name, mon_act[35], mon_act[34:25], mon_act[24:16], mon_act[15:8], mon_act[7:0],
                   mon_e.exp[35], mon_e.exp[34:25], mon_e.exp[24:16], mon_e.exp[15:8], mon_e.exp[7:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic [9:0] p, input logic t,
                               input logic h, input int n);
    fire = f;
    px = p;
    frame_tick = t;
    b_hit = h;
    step(n);
    frame_tick = 1'b0;
    b_hit = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic a, input logic [9:0] x,
                             input logic [8:0] y, input logic [7:0] s, input logic [7:0] m);
    exp_t e;
    e.name = name;
    e.is_pixel = 1'b0;
    e.exp = {a, x, y, s, m};
    sb.push_back(e);
  endtask

  task automatic checkPixel(input string name, input logic [9:0] x, input logic [8:0] y,
                            input logic p);
    exp_t e;
    vga_x = x;
    vga_y = y;
    e.name = name;
    e.is_pixel = 1'b1;
    e.exp = {35'd0, p};
    sb.push_back(e);
    step(1);
  endtask

  initial begin
    #1_000_000;
    tests_failed++;
    $display("[TB] FAIL watchdog: run did not complete, expected finish before 1000000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle behaviour
    reset = 1'b0;
    applyStimulus(0, 10'd0, 0, 0, 2);
    checkOutput("reset_state", 0, 10'd0, 9'd0, 8'd0, 8'd0);
    checkPixel("reset_pixel", 10'd0, 9'd0, 0);
    reset = 1'b1;
    applyStimulus(0, 10'd0, 1, 1, 2);
    checkOutput("idle_hit_tick", 0, 10'd0, 9'd0, 8'd0, 8'd0);

    // Launch and ship motion after launch
    applyStimulus(1, 10'd100, 0, 0, 1);
    checkOutput("launch", 1, 10'd100, 9'd216, 8'd1, 8'd0);
    applyStimulus(0, 10'd150, 0, 0, 1);
    checkOutput("bx_held", 1, 10'd100, 9'd216, 8'd1, 8'd0);

    // Three frames of travel and the bullet footprint
    applyStimulus(0, 10'd150, 1, 0, 3);
    checkOutput("three_ticks", 1, 10'd100, 9'd210, 8'd1, 8'd0);
    checkPixel("pix_top", 10'd100, 9'd210, 1);
    checkPixel("pix_bottom", 10'd100, 9'd213, 1);
    checkPixel("pix_right", 10'd101, 9'd210, 0);
    checkPixel("pix_left", 10'd99, 9'd210, 0);
    checkPixel("pix_above", 10'd100, 9'd209, 0);
    checkPixel("pix_below", 10'd100, 9'd214, 0);

    // Hit together with a frame tick, hit held, fire during cooldown
    applyStimulus(0, 10'd150, 1, 1, 1);
    checkOutput("hit_over_tick", 0, 10'd0, 9'd0, 8'd1, 8'd0);
    applyStimulus(0, 10'd150, 0, 1, 5);
    checkOutput("hit_held_hold", 0, 10'd0, 9'd0, 8'd1, 8'd0);
    applyStimulus(0, 10'd150, 1, 0, 7);
    applyStimulus(1, 10'd150, 0, 0, 1);
    applyStimulus(0, 10'd150, 0, 0, 1);
    checkOutput("fire_in_hold", 0, 10'd0, 9'd0, 8'd1, 8'd0);
    applyStimulus(0, 10'd50, 1, 0, 1);
    applyStimulus(0, 10'd50, 0, 0, 1);
    applyStimulus(1, 10'd50, 0, 0, 1);
    checkOutput("relaunch", 1, 10'd50, 9'd216, 8'd2, 8'd0);
    applyStimulus(0, 10'd50, 0, 0, 1);

    // Travel to the top row, expire, full cooldown
    applyStimulus(0, 10'd50, 1, 0, 108);
    checkOutput("at_top", 1, 10'd50, 9'd0, 8'd2, 8'd0);
    applyStimulus(0, 10'd50, 1, 0, 1);
    checkOutput("expire", 0, 10'd0, 9'd0, 8'd2, 8'd1);
    applyStimulus(0, 10'd50, 1, 0, 7);
    applyStimulus(1, 10'd50, 0, 0, 1);
    applyStimulus(0, 10'd50, 0, 0, 1);
    checkOutput("fire_late_hold", 0, 10'd0, 9'd0, 8'd2, 8'd1);
    applyStimulus(0, 10'd50, 1, 0, 1);
    applyStimulus(0, 10'd50, 0, 0, 1);
    applyStimulus(1, 10'd50, 0, 0, 1);
    checkOutput("launch_after_cd", 1, 10'd50, 9'd216, 8'd3, 8'd1);

    // Fire held through flight and cooldown
    applyStimulus(1, 10'd50, 1, 0, 109);
    checkOutput("held_expire", 0, 10'd0, 9'd0, 8'd3, 8'd2);
    applyStimulus(1, 10'd50, 1, 0, 8);
    applyStimulus(1, 10'd50, 0, 0, 1);
    applyStimulus(1, 10'd50, 0, 0, 1);
`ifdef AUTOFIRE_EN
    checkOutput("autofire", 1, 10'd50, 9'd216, 8'd4, 8'd2);
    applyStimulus(1, 10'd50, 0, 0, 3);
    checkOutput("autofire_hold", 1, 10'd50, 9'd216, 8'd4, 8'd2);
`else
    checkOutput("no_autofire", 0, 10'd0, 9'd0, 8'd3, 8'd2);
    applyStimulus(1, 10'd50, 0, 0, 3);
    checkOutput("no_autofire_hold", 0, 10'd0, 9'd0, 8'd3, 8'd2);
`endif

    // Reset from any state, then reset mid-flight
    reset = 1'b0;
    applyStimulus(0, 10'd50, 0, 0, 1);
    checkOutput("reset_any", 0, 10'd0, 9'd0, 8'd0, 8'd0);
    reset = 1'b1;
    applyStimulus(1, 10'd300, 0, 0, 1);
    checkOutput("launch_300", 1, 10'd300, 9'd216, 8'd1, 8'd0);
    applyStimulus(0, 10'd300, 1, 0, 18);
    checkOutput("by_180", 1, 10'd300, 9'd180, 8'd1, 8'd0);
    checkPixel("pix_180", 10'd300, 9'd181, 1);
    reset = 1'b0;
    applyStimulus(0, 10'd300, 0, 0, 1);
    checkOutput("reset_mid_flight", 0, 10'd0, 9'd0, 8'd0, 8'd0);
    checkPixel("pix_after_reset", 10'd300, 9'd181, 0);
    reset = 1'b1;
    applyStimulus(0, 10'd300, 1, 0, 1);
    checkOutput("idle_after_reset", 0, 10'd0, 9'd0, 8'd0, 8'd0);
    applyStimulus(1, 10'd300, 0, 0, 1);
    checkOutput("launch_post_reset", 1, 10'd300, 9'd216, 8'd1, 8'd0);
    applyStimulus(0, 10'd300, 0, 1, 1);
    applyStimulus(0, 10'd300, 1, 0, 8);
    applyStimulus(0, 10'd300, 0, 0, 1);

    // Shot counter saturation over 257 launches
    for (int n = 2; n <= 257; n++) begin
      applyStimulus(1, 10'd300, 0, 0, 1);
      if (n >= 254)
        checkOutput($sformatf("sat_%0d", n), 1, 10'd300, 9'd216,
                    (n > 255) ? 8'd255 : 8'(n), 8'd0);
      applyStimulus(0, 10'd300, 0, 1, 1);
      applyStimulus(0, 10'd300, 1, 0, 8);
      applyStimulus(0, 10'd300, 0, 0, 1);
    end
    checkOutput("sat_final_idle", 0, 10'd0, 9'd0, 8'd255, 8'd0);

    step(2);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
